// File: rtl/linear_layer_start_fifo_rd_ctrl.sv
// Read-side controller for a shift-register channel: drives the storage write-enable
// and read address, tracks occupancy and holds the head entry in a registered FWFT stage.
module linear_layer_start_fifo_rd_ctrl #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic                  srl_we,
    output logic [ADDR_WIDTH-1:0] srl_addr,
    input  logic [DATA_WIDTH-1:0] srl_dout,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic                  if_empty_n,
    output logic [DATA_WIDTH-1:0] if_dout
);

    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    generate
        if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
            $error("DEPTH does not fit in ADDR_WIDTH");
        end
    endgenerate

    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  w_count_d;
    logic [CNT_WIDTH-1:0]  w_count_m1;
    logic                  r_dout_valid;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;

    assign if_full_n  = (r_count < DEPTH_C);
    assign if_empty_n = r_dout_valid;
    assign if_dout    = r_dout;

    assign w_push = if_write & if_write_ce & if_full_n;
    assign w_pop  = if_read & if_read_ce & r_dout_valid;
    // The head register refills whenever storage is non-empty and the head is free or leaving.
    assign w_load = (r_count != '0) & (~r_dout_valid | w_pop);

    assign srl_we     = w_push;
    assign w_count_m1 = r_count - CNT_WIDTH'(1);
    assign srl_addr   = (r_count != '0) ? ADDR_WIDTH'(w_count_m1) : '0;

    // On push & load the oldest entry is read pre-shift and the next one lands at count-1.
    always_comb begin
        w_count_d = r_count;
        if (w_push && !w_load) begin
            w_count_d = r_count + CNT_WIDTH'(1);
        end else if (w_load && !w_push) begin
            w_count_d = w_count_m1;
        end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
        end else if (w_load) begin
            r_dout_valid <= 1'b1;
            r_dout       <= srl_dout;
        end else if (w_pop) begin
            r_dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_linear_layer_start_fifo_rd_ctrl.sv
// Bench for linear_layer_start_fifo_rd_ctrl with a shift-register storage model;
// accepted writes feed a scoreboard queue that a negedge monitor drains on each pop.
module tb_linear_layer_start_fifo_rd_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 1;
    localparam int unsigned DEPTH = 2;

    logic          clk;
    logic          ap_rst_n;
    logic          if_write_ce;
    logic          if_write;
    logic          if_full_n;
    logic          srl_we;
    logic [AW-1:0] srl_addr;
    logic [DW-1:0] srl_dout;
    logic          if_read_ce;
    logic          if_read;
    logic          if_empty_n;
    logic [DW-1:0] if_dout;
    logic [DW-1:0] din;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] sb_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    linear_layer_start_fifo_rd_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .ap_rst_n   (ap_rst_n),
        .if_write_ce(if_write_ce),
        .if_write   (if_write),
        .if_full_n  (if_full_n),
        .srl_we     (srl_we),
        .srl_addr   (srl_addr),
        .srl_dout   (srl_dout),
        .if_read_ce (if_read_ce),
        .if_read    (if_read),
        .if_empty_n (if_empty_n),
        .if_dout    (if_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-register storage: newest at index 0, combinational read by address.
    always @(posedge clk) begin
        if (srl_we) begin
            mem[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) mem[i] <= mem[i-1];
        end
    end
    assign srl_dout = mem[srl_addr];

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (!ap_rst_n) begin
            sb_q.delete();
        end else begin
            if (if_read && if_read_ce && if_empty_n) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: pop of %0h with nothing expected", if_dout);
                end else begin
                    check("sb_pop_data", int'(if_dout), int'(sb_q.pop_front()));
                end
            end
            if (if_write && if_write_ce && if_full_n) sb_q.push_back(din);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic wce, input logic r, input logic rce,
                         input logic [DW-1:0] d);
        if_write    = w;
        if_write_ce = wce;
        if_read     = r;
        if_read_ce  = rce;
        din         = d;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst_n = 1'b0;
        drive(0, 0, 0, 0, 8'h00);
        #3;
        check("rst_empty_n", int'(if_empty_n), 0);
        check("rst_full_n", int'(if_full_n), 1);
        check("rst_dout", int'(if_dout), 0);
        check("rst_addr", int'(srl_addr), 0);
        tick();
        ap_rst_n = 1'b1;

        // Single write: two-cycle latency to the head register.
        drive(1, 1, 0, 0, 8'h01);
        #1 check("t1_we", int'(srl_we), 1);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        check("t1_cyc1_empty_n", int'(if_empty_n), 0);
        check("t1_cyc1_full_n", int'(if_full_n), 1);
        tick();
        check("t1_cyc2_empty_n", int'(if_empty_n), 1);
        check("t1_cyc2_dout", int'(if_dout), 8'h01);
        check("t1_cyc2_full_n", int'(if_full_n), 1);
        drive(0, 0, 1, 1, 8'h00);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        check("t1_after_pop_empty_n", int'(if_empty_n), 0);

        // Three writes fill the channel; a fourth is ignored.
        drive(1, 1, 0, 0, 8'hAA);
        tick();
        drive(1, 1, 0, 0, 8'hBB);
        tick();
        drive(1, 1, 0, 0, 8'hCC);
        tick();
        check("t2_full_n", int'(if_full_n), 0);
        check("t2_addr", int'(srl_addr), 1);
        check("t2_head", int'(if_dout), 8'hAA);
        drive(1, 1, 0, 0, 8'hDD);
        #1 check("t2_blocked_we", int'(srl_we), 0);
        tick();
        check("t2_still_full", int'(if_full_n), 0);
        drive(0, 0, 1, 1, 8'h00);
        tick();
        check("t2_pop1_full_n", int'(if_full_n), 1);
        check("t2_pop1_head", int'(if_dout), 8'hBB);
        tick();
        check("t2_pop2_head", int'(if_dout), 8'hCC);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        check("t2_drained_empty_n", int'(if_empty_n), 0);

        // Continuous write and read with alternating LSB.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 1, 8'((i << 4) | (i & 1)));
            tick();
            check("t3_full_n", int'(if_full_n), 1);
            check("t3_addr", int'(srl_addr), 0);
            if (i >= 1) check("t3_empty_n", int'(if_empty_n), 1);
        end
        drive(0, 0, 1, 1, 8'h00);
        tick();
        tick();
        tick();
        drive(0, 0, 0, 0, 8'h00);
        check("t3_drained_empty_n", int'(if_empty_n), 0);

        // Simultaneous push and pop while full.
        drive(1, 1, 0, 0, 8'hE0);
        tick();
        drive(1, 1, 0, 0, 8'hE1);
        tick();
        drive(1, 1, 0, 0, 8'hE2);
        tick();
        drive(1, 1, 1, 1, 8'hE3);
        #1 check("t4_we_blocked", int'(srl_we), 0);
        tick();
        check("t4_full_n_after", int'(if_full_n), 1);
        check("t4_head", int'(if_dout), 8'hE1);
        drive(1, 1, 0, 0, 8'hE4);
        #1 check("t4_we_accepted", int'(srl_we), 1);
        tick();
        check("t4_refull", int'(if_full_n), 0);
        drive(0, 0, 1, 1, 8'h00);
        tick();
        tick();
        tick();
        drive(0, 0, 0, 0, 8'h00);
        check("t4_drained_empty_n", int'(if_empty_n), 0);

        // Ignored pop on empty and ce-gated requests.
        drive(0, 0, 1, 1, 8'h00);
        #1 check("t5_we_pop_empty", int'(srl_we), 0);
        tick();
        check("t5_empty_n", int'(if_empty_n), 0);
        check("t5_full_n", int'(if_full_n), 1);
        drive(1, 0, 1, 0, 8'h77);
        #1 check("t5_we_ce0", int'(srl_we), 0);
        tick();
        check("t5_ce0_empty_n", int'(if_empty_n), 0);
        check("t5_ce0_addr", int'(srl_addr), 0);

        // HEAD_ONLY: ce-gated read holds, then push & pop leaves one invalid cycle.
        drive(1, 1, 0, 0, 8'h31);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        tick();
        drive(0, 0, 1, 0, 8'h00);
        tick();
        check("t5_hold_empty_n", int'(if_empty_n), 1);
        check("t5_hold_dout", int'(if_dout), 8'h31);
        drive(1, 1, 1, 1, 8'h32);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        check("ho_bubble_empty_n", int'(if_empty_n), 0);
        tick();
        check("ho_reload_empty_n", int'(if_empty_n), 1);
        check("ho_reload_dout", int'(if_dout), 8'h32);
        drive(0, 0, 1, 1, 8'h00);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        check("ho_to_empty", int'(if_empty_n), 0);

        // Asynchronous reset with count=2.
        drive(1, 1, 0, 0, 8'hF0);
        tick();
        drive(1, 1, 0, 0, 8'hF1);
        tick();
        drive(1, 1, 0, 0, 8'hF2);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        check("t6_pre_full_n", int'(if_full_n), 0);
        #2 ap_rst_n = 1'b0;
        #1;
        check("t6_rst_empty_n", int'(if_empty_n), 0);
        check("t6_rst_full_n", int'(if_full_n), 1);
        check("t6_rst_dout", int'(if_dout), 0);
        check("t6_rst_addr", int'(srl_addr), 0);
        tick();
        #2 ap_rst_n = 1'b1;
        drive(1, 1, 0, 0, 8'h5A);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        check("t6_cyc1_empty_n", int'(if_empty_n), 0);
        tick();
        check("t6_cyc2_empty_n", int'(if_empty_n), 1);
        check("t6_cyc2_dout", int'(if_dout), 8'h5A);
        drive(0, 0, 1, 1, 8'h00);
        tick();
        drive(0, 0, 0, 0, 8'h00);
        check("t6_final_empty_n", int'(if_empty_n), 0);
        tick();
        check("sb_leftover", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
